// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states and datapath select encodings for the multicycle RV32I controller
package riscv_ctrl_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, JAL, BEQ
  } state_t;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC       = 2'b00;
  localparam logic [1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [1:0] SRCA_RS1      = 2'b10;
  localparam logic [1:0] SRCB_RS2      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;
  localparam logic [1:0] ALUOP_ADD     = 2'b00;
  localparam logic [1:0] ALUOP_SUB     = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT   = 2'b10;
  localparam logic [1:0] IMM_I         = 2'b00;
  localparam logic [1:0] IMM_S         = 2'b01;
  localparam logic [1:0] IMM_B         = 2'b10;
  localparam logic [1:0] IMM_J         = 2'b11;
  function automatic state_t decode_next(input logic [6:0] op);
    return (op == OP_LOAD || op == OP_STORE) ? MEMADR :
           (op == OP_R)   ? EXEC_R :
           (op == OP_I)   ? EXEC_I :
           (op == OP_JAL) ? JAL :
           (op == OP_BEQ) ? BEQ : FETCH;
  endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: opcode/flag/handshake inputs and datapath control outputs of the sequencer
interface multicycle_controller_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       illegal;
  modport master (
    input  op, zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal
  );
  modport slave (
    output op, zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal
  );
endinterface

// File: rtl/imm_src_decoder.sv
// imm_src_decoder: immediate format and supported-opcode flag from the opcode field
module imm_src_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src,
  output logic       legal
);
  always_comb begin
    imm_src = (op == OP_STORE) ? IMM_S :
              (op == OP_BEQ)   ? IMM_B :
              (op == OP_JAL)   ? IMM_J : IMM_I;
    legal   = op inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BEQ};
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: fetch/decode/execute/memory/writeback sequencer with memory-ready stalls
// and a retired-instruction counter.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_controller_if.master bus,
  output logic [CNT_W-1:0]     instret
);
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic [1:0]         imm_src;
  logic               legal;
  logic               retire;
  imm_src_decoder u_imm (
    .op      (bus.op),
    .imm_src (imm_src),
    .legal   (legal)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    bus.PCWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_RS2;
    bus.ALUOp     = ALUOP_ADD;
    bus.ImmSrc    = imm_src;
    bus.illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        bus.IRWrite   = bus.mem_ready;
        bus.PCWrite   = bus.mem_ready;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        state_d       = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        bus.illegal = !legal;
        state_d     = decode_next(bus.op);
      end
      MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        state_d     = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        state_d    = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.ResultSrc = RES_DATA;
        bus.RegWrite  = 1'b1;
        state_d       = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        state_d      = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXEC_R: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUOp   = ALUOP_FUNCT;
        state_d     = ALUWB;
      end
      EXEC_I: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALUOP_FUNCT;
        state_d     = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        state_d      = FETCH;
      end
      JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        bus.PCWrite = 1'b1;
        state_d     = ALUWB;
      end
      BEQ: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUOp   = ALUOP_SUB;
        bus.PCWrite = bus.zero;
        state_d     = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // an illegal-opcode bounce from DECODE is not a retirement
    retire    = (state_d == FETCH) && (state_q inside {MEMWB, MEMWRITE, ALUWB, BEQ});
    instret_d = instret_q + CNT_W'(retire);
  end
  assign instret = instret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench comparing every cycle's control outputs and instret
// against a state-table reference driven by the same opcode/zero/mem_ready stimulus.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;
  localparam int CNT_W = 4;
  typedef struct packed {
    logic [15:0]      o;
    logic [CNT_W-1:0] n;
  } exp_t;
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CNT_W-1:0] instret;
  multicycle_controller_if bus ();
  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.master),
    .instret (instret)
  );
  always #5 clk = ~clk;
  int               n_chk = 0;
  int               n_err = 0;
  exp_t             sb[$];
  state_t           mst = FETCH;
  logic [CNT_W-1:0] mcnt = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] got_vec();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.ResultSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc, bus.illegal};
  endfunction
  function automatic logic [15:0] model_out(input state_t s, input logic [6:0] o, input logic z, input logic mr);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] res = 2'b00, sa = 2'b00, sbb = 2'b00, aop = 2'b00, imm;
    imm = (o == 7'b0100011) ? 2'b01 : (o == 7'b1100011) ? 2'b10 : (o == 7'b1101111) ? 2'b11 : 2'b00;
    case (s)
      FETCH:    begin irw = mr; pcw = mr; sbb = 2'b10; res = 2'b10; end
      DECODE:   begin sa = 2'b01; sbb = 2'b01;
                  ill = !(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011}); end
      MEMADR:   begin sa = 2'b10; sbb = 2'b01; end
      MEMREAD:  adr = 1;
      MEMWB:    begin res = 2'b01; rw = 1; end
      MEMWRITE: begin adr = 1; mw = 1; end
      EXEC_R:   begin sa = 2'b10; aop = 2'b10; end
      EXEC_I:   begin sa = 2'b10; sbb = 2'b01; aop = 2'b10; end
      ALUWB:    rw = 1;
      JAL:      begin sa = 2'b01; sbb = 2'b10; pcw = 1; end
      BEQ:      begin sa = 2'b10; aop = 2'b01; pcw = z; end
      default:  ;
    endcase
    return {pcw, adr, mw, irw, rw, res, sa, sbb, aop, imm, ill};
  endfunction
  function automatic state_t model_next(input state_t s, input logic [6:0] o, input logic mr);
    case (s)
      FETCH:    return mr ? DECODE : FETCH;
      DECODE:   case (o)
                  7'b0000011, 7'b0100011: return MEMADR;
                  7'b0110011: return EXEC_R;
                  7'b0010011: return EXEC_I;
                  7'b1101111: return JAL;
                  7'b1100011: return BEQ;
                  default:    return FETCH;
                endcase
      MEMADR:   return (o == 7'b0000011) ? MEMREAD : MEMWRITE;
      MEMREAD:  return mr ? MEMWB : MEMREAD;
      MEMWRITE: return mr ? FETCH : MEMWRITE;
      EXEC_R, EXEC_I, JAL: return ALUWB;
      default:  return FETCH;
    endcase
  endfunction
  task automatic cyc(input logic [6:0] o, input logic z, input logic mr);
    exp_t   e;
    state_t nx;
    bus.op = o;
    bus.zero = z;
    bus.mem_ready = mr;
    e.o = model_out(mst, o, z, mr);
    e.n = mcnt;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk("outputs", {16'h0, got_vec()}, {16'h0, e.o});
    chk("instret", 32'(instret), 32'(e.n));
    nx = model_next(mst, o, mr);
    if (nx == FETCH && (mst == MEMWB || mst == MEMWRITE || mst == ALUWB || mst == BEQ)) mcnt++;
    mst = nx;
    @(posedge clk);
    #1;
  endtask
  task automatic run_instr(input logic [6:0] o, input logic z, input int fs, input int ms, input int lat);
    int   n = 0;
    bit   left = 0;
    logic mr;
    do begin
      if (mst == FETCH) begin
        mr = (fs == 0);
        if (fs > 0) fs--;
      end else if (mst == MEMREAD || mst == MEMWRITE) begin
        mr = (ms == 0);
        if (ms > 0) ms--;
      end else mr = 1'($urandom_range(0, 1));
      cyc(o, z, mr);
      n++;
      if (mst != FETCH) left = 1;
    end while (!(left && mst == FETCH) && n < 40);
    chk("latency", 32'(n), 32'(lat));
  endtask
  function automatic int lat_of(input logic [6:0] o);
    case (o)
      7'b1100011: return 3;
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      default:    return 2;
    endcase
  endfunction
  logic [6:0] ops [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                          7'b1101111, 7'b1100011, 7'b1111111, 7'b0110111};
  initial begin
    bus.op = 7'b0110011;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_irwrite", 32'(bus.IRWrite), 1);
    chk("rst_pcwrite", 32'(bus.PCWrite), 1);
    chk("rst_vec", {16'h0, got_vec()}, {16'h0, model_out(FETCH, 7'b0110011, 0, 1)});
    chk("rst_instret", 32'(instret), 0);
    bus.mem_ready = 1'b0;
    #1;
    chk("rst_vec_nordy", {16'h0, got_vec()}, {16'h0, model_out(FETCH, 7'b0110011, 0, 0)});
    @(posedge clk);
    #1;
    reset = 1'b0;
    mst = FETCH;
    mcnt = '0;
    run_instr(OP_R, 0, 0, 0, 4);
    chk("r_instret", 32'(instret), 1);
    run_instr(OP_LOAD, 0, 0, 2, 7);
    run_instr(OP_BEQ, 1, 0, 0, 3);
    run_instr(OP_BEQ, 0, 0, 0, 3);
    chk("beq_instret", 32'(instret), 4);
    run_instr(7'b1111111, 0, 0, 0, 2);
    chk("illegal_instret", 32'(instret), 4);
    run_instr(OP_STORE, 0, 1, 1, 6);
    run_instr(OP_JAL, 0, 0, 0, 4);
    run_instr(OP_I, 0, 2, 0, 6);
    for (int i = 0; i < 24; i++) begin
      logic [6:0] o;
      int fs, ms;
      o = ops[$urandom_range(0, 7)];
      fs = $urandom_range(0, 2);
      ms = $urandom_range(0, 2);
      run_instr(o, 1'($urandom_range(0, 1)), fs, ms,
                lat_of(o) + fs + ((o == OP_LOAD || o == OP_STORE) ? ms : 0));
    end
    cyc(OP_STORE, 0, 1);
    cyc(OP_STORE, 0, 1);
    cyc(OP_STORE, 0, 1);
    cyc(OP_STORE, 0, 0);
    @(negedge clk);
    chk("mw_before_reset", 32'(bus.MemWrite), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("mw_in_reset", 32'(bus.MemWrite), 0);
    chk("reset_vec", {16'h0, got_vec()}, {16'h0, model_out(FETCH, OP_STORE, 0, 0)});
    chk("reset_instret", 32'(instret), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mst = FETCH;
    mcnt = '0;
    run_instr(OP_R, 0, 0, 0, 4);
    chk("post_reset_instret", 32'(instret), 1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing FSM for the multicycle RV32I core variant. It replaces the single-cycle main decoder and walks each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. It drives the shared datapath's register enables and mux selects and stalls on a memory ready handshake. It sits between the instruction register opcode field and the datapath, next to the existing ALU decoder, which still consumes ALUOp.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- op  in  7  opcode field of the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  unified memory has completed the current access
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction and OldPC register enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = const 4
- ALUOp  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- illegal  out  1  one-cycle pulse, unsupported opcode decoded
- instret  out  CNT_W  retired-instruction count

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, JAL, BEQ.
- Asserted outputs per state. Every output not listed is 0. ALUSrcA, ALUSrcB and ResultSrc default to 00.
  - FETCH: IRWrite = mem_ready, PCWrite = mem_ready, ALUSrcB = 10, ResultSrc = 10. Exits to DECODE only when mem_ready = 1.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01 (computes the branch/jump target).
  - DECODE exits by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1101111 → JAL
    - 1100011 → BEQ
    - any other opcode → FETCH, with illegal = 1 for that cycle
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01. Goes to MEMREAD if op = 0000011, otherwise to MEMWRITE.
  - MEMREAD: AdrSrc = 1. Waits for mem_ready, then goes to MEMWB.
  - MEMWB: ResultSrc = 01, RegWrite = 1. Goes to FETCH.
  - MEMWRITE: AdrSrc = 1, MemWrite = 1, held until mem_ready. Then goes to FETCH.
  - EXEC_R: ALUSrcA = 10, ALUOp = 10. Goes to ALUWB.
  - EXEC_I: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10. Goes to ALUWB.
  - ALUWB: RegWrite = 1. Goes to FETCH.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, PCWrite = 1. Goes to ALUWB.
  - BEQ: ALUSrcA = 10, ALUOp = 01, PCWrite = zero. Goes to FETCH.
- ImmSrc is decoded combinationally from op in every state: I for load/OP-IMM, S for store, B for branch, J for JAL, 00 otherwise.
- instret increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - An illegal-opcode return from DECODE does not count.
  - The counter wraps modulo 2^CNT_W.

## Timing
- State register and instret reset asynchronously to FETCH and 0.
- Outputs are a function of the state plus op, zero and mem_ready only. Under reset they equal the FETCH values:
  - all enables 0 except IRWrite = PCWrite = mem_ready
  - ALUSrcB = 10, ResultSrc = 10
- Latency with no wait states: branch 3 cycles; R/I-type 4; store 4; JAL 4; load 5.
- Each mem_ready = 0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle. During a stall all outputs stay stable and no register enable pulses.
- mem_ready is sampled only in FETCH, MEMREAD and MEMWRITE and ignored in all other states.
- Reset asserted mid-instruction aborts it. No write enables are asserted while reset is high (IRWrite/PCWrite excepted, as above), and instret does not count the aborted instruction.

## Structure
- Shared package riscv_ctrl_pkg holds:
  - opcode constants
  - the state enum
  - ResultSrc / ALUSrcA / ALUSrcB / ALUOp / ImmSrc encodings
- One combinational sub-module, imm_src_decoder, produces ImmSrc and the opcode-legal flag from op.
- FSM and counter live in the top.

## Test plan
- Reset asserted, then released with mem_ready = 1 → state FETCH, instret = 0, IRWrite = PCWrite = 1, ALUSrcB = 10, ResultSrc = 10.
- R-type add (op 0110011), mem_ready tied to 1 → RegWrite = 1 on cycle 4 only, ALUOp = 10 on cycle 3, instret = 1 on cycle 5.
- Load (op 0000011) with mem_ready low for 2 cycles in MEMREAD → AdrSrc held at 1 for 3 cycles, then MEMWB with ResultSrc = 01 and RegWrite = 1, total 7 cycles.
- beq with zero = 1, then zero = 0 → PCWrite = 1 in BEQ for the first, PCWrite = 0 for the second, ALUOp = 01 in both, instret advances by 2.
- Illegal op 1111111 → illegal pulses for 1 cycle in DECODE, next state FETCH, instret unchanged, no RegWrite or MemWrite.
- Reset asserted during MEMWRITE with mem_ready = 0 → MemWrite drops immediately, state FETCH, instret not incremented.
